// File: rtl/qtree_heap_write_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// qtree_heap_write_arbiter_pkg
//   Shared types for the QTree_Bool heap write arbiter: the heap node payload,
//   the heap pointer type and its "don't care" value, and the default heap
//   address width.
//   A pointer is {address, 1'b1}. The low tag bit distinguishes a heap
//   reference from an inline leaf, so a zero pointer never names a node.
// -----------------------------------------------------------------------------
package qtree_heap_write_arbiter_pkg;

   // Default heap address width; the pointer carries one extra tag bit.
   localparam int QT_ADDR_W = 15;

   typedef logic [QT_ADDR_W:0] Pointer_QTree_Bool_t;

   // Value driven on pointer outputs when nothing is being returned.
   localparam Pointer_QTree_Bool_t Pointer_QTree_Bool_dc = '0;

   typedef enum logic [1:0] {
      QT_EMPTY = 2'd0,
      QT_FULL  = 2'd1,
      QT_NODE  = 2'd2,
      QT_RSVD  = 2'd3
   } qt_kind_e;

   // One heap word: node kind plus four quadrant child pointers.
   typedef struct packed {
      qt_kind_e                  kind;
      Pointer_QTree_Bool_t [3:0] child;
   } QTree_Bool_t;

   localparam int QT_W = $bits(QTree_Bool_t);

endpackage

// File: rtl/qtree_heap_write_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// qtree_heap_write_arbiter_rr_pick
//   Combinational cyclic priority encoder. Picks the first asserted request
//   at or after i_ptr, wrapping from N_REQ-1 back to 0.
// Ports
//   i_req  [N_REQ]  request vector
//   i_ptr  [IDX_W]  search start index (always < N_REQ)
//   o_gnt  [N_REQ]  one-hot pick, zero when no request
//   o_idx  [IDX_W]  binary index of the pick, zero when no request
//   o_any           at least one request asserted
// -----------------------------------------------------------------------------
module qtree_heap_write_arbiter_rr_pick #(
   parameter int N_REQ = 4,
   parameter int IDX_W = 2
) (
   input  logic [N_REQ-1:0] i_req,
   input  logic [IDX_W-1:0] i_ptr,
   output logic [N_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_any
);

   // Walk the requests from i_ptr cyclically; the first hit wins.
   always_comb begin
      int                 w_pos;
      logic [IDX_W-1:0]   w_cand;
      o_gnt  = '0;
      o_idx  = '0;
      o_any  = 1'b0;
      w_pos  = 0;
      w_cand = '0;
      for (int k = 0; k < N_REQ; k++) begin
         w_pos  = (int'(i_ptr) + k) % N_REQ;
         w_cand = IDX_W'(w_pos);
         if (!o_any && i_req[w_cand]) begin
            o_any         = 1'b1;
            o_idx         = w_cand;
            o_gnt         = '0;
            o_gnt[w_cand] = 1'b1;
         end else begin
            o_any = o_any;
         end
      end
   end

endmodule

// File: rtl/qtree_heap_write_arbiter.sv
// -----------------------------------------------------------------------------
// qtree_heap_write_arbiter
//   Round-robin arbiter sharing the single QTree_Bool heap write port among
//   N_REQ node-building streams. It grants one node per cycle and hands the
//   winner the next free heap address from a bump allocator. The heap write
//   and the pointer response appear one cycle after the grant. The allocator
//   never wraps: once the last address is handed out, heap_full sticks and all
//   requests stall until clear.
// Configuration macro
//   QTREE_ARB_STATS_EN : adds per-channel saturating grant counters and a
//                        stall-cycle counter. Both are cleared by aresetn and
//                        by clear.
// Ports
//   clk, aresetn  clock (rising edge) and async active-low reset
//   clear         synchronous heap clear: allocator, full flag, rr pointer
//   req_valid     per-channel node write request
//   req_data      node payloads, channel i in slice i
//   req_ready     one-hot grant, combinational from state and req_valid
//   rsp_valid     one-cycle pulse: rsp_ptr belongs to that channel
//   rsp_ptr       allocated pointer {addr, 1'b1}, registered
//   mem_we, mem_addr, mem_wdata   registered heap write port
//   heap_full     sticky allocator-exhausted flag
//   grant_cnt, stall_cnt          statistics (QTREE_ARB_STATS_EN only)
// -----------------------------------------------------------------------------
module qtree_heap_write_arbiter
   import qtree_heap_write_arbiter_pkg::*;
#(
   parameter int N_REQ      = 4,
   parameter int ADDR_W     = QT_ADDR_W,
   parameter int HEAP_DEPTH = 32768
) (
   input  logic                  clk,
   input  logic                  aresetn,
   input  logic                  clear,
   input  logic [N_REQ-1:0]      req_valid,
   input  logic [N_REQ*QT_W-1:0] req_data,
   output logic [N_REQ-1:0]      req_ready,
   output logic [N_REQ-1:0]      rsp_valid,
   output logic [ADDR_W:0]       rsp_ptr,
   output logic                  mem_we,
   output logic [ADDR_W-1:0]     mem_addr,
   output logic [QT_W-1:0]       mem_wdata,
   output logic                  heap_full
`ifdef QTREE_ARB_STATS_EN
   ,
   output logic [N_REQ*16-1:0]   grant_cnt,
   output logic [15:0]           stall_cnt
`endif
);

   localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W+1)'(HEAP_DEPTH - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

   logic [IDX_W-1:0]  r_rr_ptr;
   // One bit wider than the address so the count after the final grant
   // (HEAP_DEPTH) is representable and never aliases back to address 0.
   logic [ADDR_W:0]   r_alloc;
   logic              r_heap_full;

   logic              r_mem_we;
   logic [ADDR_W-1:0] r_mem_addr;
   logic [QT_W-1:0]   r_mem_wdata;
   logic [N_REQ-1:0]  r_rsp_valid;
   logic [ADDR_W:0]   r_rsp_ptr;

   logic [N_REQ-1:0]  w_pick;
   logic [IDX_W-1:0]  w_idx;
   logic              w_any;
   logic              w_enable;
   logic              w_grant;
   logic [IDX_W-1:0]  w_rr_next;
   logic [QT_W-1:0]   w_gnt_data;

   qtree_heap_write_arbiter_rr_pick #(
      .N_REQ (N_REQ),
      .IDX_W (IDX_W)
   ) u_rr_pick (
      .i_req (req_valid),
      .i_ptr (r_rr_ptr),
      .o_gnt (w_pick),
      .o_idx (w_idx),
      .o_any (w_any)
   );

   // No grants while the heap is full or being cleared; stalled requests stay pending.
   assign w_enable  = !r_heap_full && !clear;
   assign w_grant   = w_any && w_enable;
   assign req_ready = w_enable ? w_pick : '0;
   assign w_rr_next = (w_idx == LAST_IDX) ? '0 : (w_idx + IDX_W'(1));

   // Payload mux for the winning channel.
   always_comb begin
      w_gnt_data = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (w_pick[i]) begin
            w_gnt_data = req_data[i*QT_W +: QT_W];
         end else begin
            w_gnt_data = w_gnt_data;
         end
      end
   end

   // Bump allocator, sticky full flag and round-robin pointer.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_rr_ptr    <= '0;
         r_alloc     <= '0;
         r_heap_full <= 1'b0;
      end else if (clear) begin
         r_rr_ptr    <= '0;
         r_alloc     <= '0;
         r_heap_full <= 1'b0;
      end else if (w_grant) begin
         r_rr_ptr <= w_rr_next;
         r_alloc  <= r_alloc + (ADDR_W+1)'(1);
         if (r_alloc == LAST_ADDR) begin
            r_heap_full <= 1'b1;
         end
      end
   end

   // Heap write port and pointer response, one cycle after the grant.
   // Not affected by clear, so a write granted just before a clear completes.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rsp_valid <= '0;
         r_rsp_ptr   <= '0;
      end else if (w_grant) begin
         r_mem_we    <= 1'b1;
         r_mem_addr  <= r_alloc[ADDR_W-1:0];
         r_mem_wdata <= w_gnt_data;
         r_rsp_valid <= w_pick;
         r_rsp_ptr   <= {r_alloc[ADDR_W-1:0], 1'b1};
      end else begin
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_rsp_valid <= '0;
         r_rsp_ptr   <= '0;
      end
   end

   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign rsp_valid = r_rsp_valid;
   assign rsp_ptr   = r_rsp_ptr;
   assign heap_full = r_heap_full;

`ifdef QTREE_ARB_STATS_EN
   logic [N_REQ-1:0][15:0] r_grant_cnt;
   logic [15:0]            r_stall_cnt;

   // Saturating per-channel grant counters and stall-cycle counter.
   always_ff @(posedge clk or negedge aresetn) begin
      if (!aresetn) begin
         r_grant_cnt <= '0;
         r_stall_cnt <= '0;
      end else if (clear) begin
         r_grant_cnt <= '0;
         r_stall_cnt <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (w_grant && w_pick[i] && (r_grant_cnt[i] != 16'hFFFF)) begin
               r_grant_cnt[i] <= r_grant_cnt[i] + 16'd1;
            end
         end
         if ((|req_valid) && !w_grant && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
         end
      end
   end

   assign grant_cnt = r_grant_cnt;
   assign stall_cnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_qtree_heap_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_qtree_heap_write_arbiter
//   Directed bench for qtree_heap_write_arbiter with N_REQ=4, ADDR_W=15 and a
//   16-word heap, so the exhaustion path is short.
//   Stats ports are connected and checked only when QTREE_ARB_STATS_EN is
//   defined.
// -----------------------------------------------------------------------------
module tb_qtree_heap_write_arbiter;
   import qtree_heap_write_arbiter_pkg::*;

   localparam int TB_NREQ  = 4;
   localparam int TB_AW    = 15;
   localparam int TB_DEPTH = 16;

   logic                    clk;
   logic                    aresetn;
   logic                    clear;
   logic [TB_NREQ-1:0]      req_valid;
   logic [TB_NREQ*QT_W-1:0] req_data;
   logic [TB_NREQ-1:0]      req_ready;
   logic [TB_NREQ-1:0]      rsp_valid;
   logic [TB_AW:0]          rsp_ptr;
   logic                    mem_we;
   logic [TB_AW-1:0]        mem_addr;
   logic [QT_W-1:0]         mem_wdata;
   logic                    heap_full;
`ifdef QTREE_ARB_STATS_EN
   logic [TB_NREQ*16-1:0]   grant_cnt;
   logic [15:0]             stall_cnt;
`endif

   int n_checks;
   int n_fail;
   logic [QT_W-1:0] tb_data [TB_NREQ];

   qtree_heap_write_arbiter #(
      .N_REQ      (TB_NREQ),
      .ADDR_W     (TB_AW),
      .HEAP_DEPTH (TB_DEPTH)
   ) u_dut (
      .clk       (clk),
      .aresetn   (aresetn),
      .clear     (clear),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_ptr   (rsp_ptr),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .heap_full (heap_full)
`ifdef QTREE_ARB_STATS_EN
      ,
      .grant_cnt (grant_cnt),
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One arbitration cycle: drive inputs, check the combinational grant, then
   // check the registered write/response that the grant produces.
   task automatic run_cycle(input string tag, input logic [3:0] valid, input logic clr,
                            input logic [3:0] exp_rdy, input logic [14:0] exp_addr,
                            input logic exp_full);
      logic [QT_W-1:0] exp_d;
      req_valid = valid;
      clear     = clr;
      #1;
      check({tag, ".ready"}, 128'(req_ready), 128'(exp_rdy));
      @(posedge clk);
      #1;
      clear = 1'b0;
      exp_d = '0;
      for (int i = 0; i < TB_NREQ; i++) begin
         if (exp_rdy[i]) exp_d = tb_data[i];
      end
      check({tag, ".we"}, 128'(mem_we), 128'(|exp_rdy));
      check({tag, ".rsp_valid"}, 128'(rsp_valid), 128'(exp_rdy));
      check({tag, ".full"}, 128'(heap_full), 128'(exp_full));
      if (exp_rdy != 4'b0000) begin
         check({tag, ".addr"}, 128'(mem_addr), 128'(exp_addr));
         check({tag, ".ptr"}, 128'(rsp_ptr), 128'({exp_addr, 1'b1}));
         check({tag, ".wdata"}, 128'(mem_wdata), 128'(exp_d));
      end else begin
         check({tag, ".ptr_idle"}, 128'(rsp_ptr), 128'(0));
      end
   endtask

   task automatic pulse_reset();
      aresetn = 1'b0;
      @(posedge clk);
      #1;
      aresetn = 1'b1;
   endtask

   logic [3:0] s2_valid [5];
   logic [3:0] s2_rdy   [5];

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      aresetn   = 1'b0;
      clear     = 1'b0;
      req_valid = 4'b0000;
      for (int i = 0; i < TB_NREQ; i++) begin
         tb_data[i] = {2'd2, 64'hC0DE_0000_0000_0000 + 64'(i * 16'h1111 + 3)};
      end
      req_data = {tb_data[3], tb_data[2], tb_data[1], tb_data[0]};

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst.we", 128'(mem_we), 128'(0));
      check("rst.rsp_valid", 128'(rsp_valid), 128'(0));
      check("rst.ptr", 128'(rsp_ptr), 128'(0));
      check("rst.addr", 128'(mem_addr), 128'(0));
      check("rst.full", 128'(heap_full), 128'(0));
      check("rst.ready", 128'(req_ready), 128'(0));
      aresetn = 1'b1;

      // Scenario 1: all channels valid, rotating grants, addresses 0..7
      for (int k = 0; k < 8; k++) begin
         run_cycle("s1", 4'b1111, 1'b0, 4'b0001 << (k % 4), 15'(k), 1'b0);
      end
      run_cycle("s1_idle", 4'b0000, 1'b0, 4'b0000, 15'd0, 1'b0);

      // Scenario 2: ch2 alone, then ch0+ch2; rr pointer wraps 3 -> 0
      s2_valid = '{4'b0100, 4'b0100, 4'b0100, 4'b0101, 4'b0100};
      s2_rdy   = '{4'b0100, 4'b0100, 4'b0100, 4'b0001, 4'b0100};
      for (int k = 0; k < 5; k++) begin
         run_cycle("s2", s2_valid[k], 1'b0, s2_rdy[k], 15'(8 + k), 1'b0);
      end

      // Scenario 3: fill the 16-word heap from ch1, stall, then clear
      pulse_reset();
      for (int k = 0; k < TB_DEPTH; k++) begin
         run_cycle("s3", 4'b0010, 1'b0, 4'b0010, 15'(k), (k == TB_DEPTH - 1));
      end
      for (int k = 0; k < 3; k++) begin
         run_cycle("s3_stall", 4'b0010, 1'b0, 4'b0000, 15'd0, 1'b1);
      end
`ifdef QTREE_ARB_STATS_EN
      check("s3.grant_cnt1", 128'(grant_cnt[31:16]), 128'(TB_DEPTH));
      check("s3.stall_cnt", 128'(stall_cnt), 128'(3));
`endif
      run_cycle("s3_clr", 4'b0010, 1'b1, 4'b0000, 15'd0, 1'b0);
`ifdef QTREE_ARB_STATS_EN
      check("s3.grant_cnt_clr", 128'(grant_cnt), 128'(0));
      check("s3.stall_cnt_clr", 128'(stall_cnt), 128'(0));
`endif
      run_cycle("s3_post", 4'b0010, 1'b0, 4'b0010, 15'd0, 1'b0);

      // Scenario 4: clear together with all requests, then ch0 wins at addr 0
      run_cycle("s4_clr", 4'b1111, 1'b1, 4'b0000, 15'd0, 1'b0);
      run_cycle("s4", 4'b1111, 1'b0, 4'b0001, 15'd0, 1'b0);

      // Scenario 5: reset lands on a pending grant; no write emerges
      req_valid = 4'b1111;
      #1;
      check("s5.ready_pre", 128'(req_ready), 128'(4'b0010));
      aresetn = 1'b0;
      @(posedge clk);
      #1;
      check("s5.we", 128'(mem_we), 128'(0));
      check("s5.rsp_valid", 128'(rsp_valid), 128'(0));
      aresetn = 1'b1;
      run_cycle("s5_next", 4'b1111, 1'b0, 4'b0001, 15'd0, 1'b0);
      run_cycle("s5_next2", 4'b1110, 1'b0, 4'b0010, 15'd1, 1'b0);
      run_cycle("s5_idle", 4'b0000, 1'b0, 4'b0000, 15'd0, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
